uart_rx_ascii: RTL

Asynchronous serial receiver for the plotter's command path. It samples the host's 8N1 UART line and recovers each ASCII command byte: 'f' (forward), 'r' (right) and digits '0'–'9'. It presents each byte as a held value plus a one-cycle strobe. It sits directly upstream of the ASCII-to-seven-segment decoder and the command parser, both of which consume `data`.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx_ascii.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the plotter command path.
// No logic; types and constants only.
// Not applicable: no data flow through this package.
package uart_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 50 MHz core clock at 115200 baud.
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  // ASCII command codes understood by the downstream parser.
  localparam logic [7:0] ASCII_F = 8'd102;
  localparam logic [7:0] ASCII_R = 8'd114;
  localparam logic [7:0] ASCII_0 = 8'd48;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Latency: 2 clk cycles from an input edge to q.
// No backpressure: level signal, sampled every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input; both stages reset to RST_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ascii.sv
// 8N1 UART receiver: recovers command bytes, presents held data plus one-cycle strobes.
// Latency: 3 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles from start edge to valid.
// No backpressure: valid/frame_err are single-cycle pulses the consumer must take.
module uart_rx_ascii
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_s;
  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shreg_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          armed_q;

  logic          bit_end;
  logic          cnt_clr;
  logic          shift_en;
  logic          stop_ok;
  logic          stop_bad;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; leaving STOP at mid-bit keeps an immediately following start bit in view.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s && armed_q)            state_d = START;
      START:   if (cnt_q == CNT_MID)            state_d = rx_s ? IDLE : DATA;
      DATA:    if (bit_end && idx_q == 3'd7)    state_d = STOP;
      STOP:    if (bit_end)                     state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // Per-state datapath controls: counter clear, bit shift and stop-bit verdict.
  always_comb begin
    cnt_clr  = 1'b1;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE:  cnt_clr = 1'b1;
      START: cnt_clr = (cnt_q == CNT_MID);
      DATA: begin
        cnt_clr  = bit_end;
        shift_en = bit_end;
      end
      STOP: begin
        cnt_clr  = bit_end;
        stop_ok  = bit_end &&  rx_s;
        stop_bad = bit_end && !rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Datapath: bit timing, LSB-first shift, output register and break re-arm flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + 1'b1;
      if (shift_en) begin
        idx_q   <= idx_q + 3'd1;
        shreg_q <= {rx_s, shreg_q[7:1]};
      end else if (state_q != DATA) begin
        idx_q <= '0;
      end
      if (stop_ok) data_q <= shreg_q;
      valid_q <= stop_ok;
      ferr_q  <= stop_bad;
      // A low stop bit disarms until the line has been seen high in IDLE, so a break reports once.
      if (stop_bad)                   armed_q <= 1'b0;
      else if (state_q == IDLE && rx_s) armed_q <= 1'b1;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule
